// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the three buses around the memory arbiter: fetch, data and the shared downstream port.
// The slave modport is the arbiter's view; master is the core/memory environment's view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  ireq_valid;
  logic [ADDR_W-1:0]     ireq_addr;
  logic                  iresp_addr_ok;
  logic                  iresp_data_ok;
  logic [31:0]           iresp_data;

  logic                  dreq_valid;
  logic [ADDR_W-1:0]     dreq_addr;
  logic [2:0]            dreq_size;
  logic [DATA_W/8-1:0]   dreq_strobe;
  logic [DATA_W-1:0]     dreq_data;
  logic                  dresp_addr_ok;
  logic                  dresp_data_ok;
  logic [DATA_W-1:0]     dresp_data;

  logic                  creq_valid;
  logic                  creq_is_write;
  logic [ADDR_W-1:0]     creq_addr;
  logic [2:0]            creq_size;
  logic [DATA_W/8-1:0]   creq_strobe;
  logic [DATA_W-1:0]     creq_data;
  logic                  cresp_ok;
  logic [DATA_W-1:0]     cresp_data;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data,
    input  cresp_ok, cresp_data
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data,
    output cresp_ok, cresp_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat memory port between the instruction-fetch and data buses.
// Round-robin or fixed data-bus priority; one idle bubble separates consecutive grants.
module mem_bus_arbiter #(
  parameter bit FIXED_DPRIO = 1'b0,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;   // 0 = ibus was served last, 1 = dbus
  logic   pick_d;
  logic   i_done;
  logic   d_done;

  // dbus wins when alone, always under fixed priority, or when ibus had the last turn.
  assign pick_d = bus.dreq_valid &&
                  (!bus.ireq_valid || FIXED_DPRIO || (last_grant == 1'b0));

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      bus.creq_valid    <= 1'b0;
      bus.creq_is_write <= 1'b0;
      bus.creq_addr     <= {ADDR_W{1'b0}};
      bus.creq_size     <= 3'b000;
      bus.creq_strobe   <= {(DATA_W/8){1'b0}};
      bus.creq_data     <= {DATA_W{1'b0}};
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            state             <= GRANT_D;
            bus.creq_valid    <= 1'b1;
            bus.creq_is_write <= |bus.dreq_strobe;
            bus.creq_addr     <= bus.dreq_addr;
            bus.creq_size     <= bus.dreq_size;
            bus.creq_strobe   <= bus.dreq_strobe;
            bus.creq_data     <= bus.dreq_data;
          end else if (bus.ireq_valid) begin
            state             <= GRANT_I;
            bus.creq_valid    <= 1'b1;
            bus.creq_is_write <= 1'b0;
            bus.creq_addr     <= bus.ireq_addr;
            bus.creq_size     <= 3'b010;
            bus.creq_strobe   <= {(DATA_W/8){1'b0}};
            bus.creq_data     <= {DATA_W{1'b0}};
          end
        end
        GRANT_I, GRANT_D: begin
          // Request fields stay frozen until memory completes; only then drop back to IDLE.
          if (bus.cresp_ok) begin
            state          <= IDLE;
            bus.creq_valid <= 1'b0;
            last_grant     <= (state == GRANT_D);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is steered only to the port that owns the grant; cresp_ok in IDLE is dropped.
  assign i_done = (state == GRANT_I) && bus.cresp_ok;
  assign d_done = (state == GRANT_D) && bus.cresp_ok;

  assign bus.iresp_addr_ok = i_done;
  assign bus.iresp_data_ok = i_done;
  assign bus.iresp_data    = !i_done         ? 32'h0 :
                             bus.creq_addr[2] ? bus.cresp_data[32 +: 32] :
                                                bus.cresp_data[0 +: 32];

  assign bus.dresp_addr_ok = d_done;
  assign bus.dresp_data_ok = d_done;
  assign bus.dresp_data    = d_done ? bus.cresp_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with random traffic, random memory
// latency, spurious completions and random resets, comparing against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SW   = DW / 8;
  localparam int NCYC = 3000;

  typedef struct packed {
    logic          iaok;
    logic          idok;
    logic [31:0]   idata;
    logic          daok;
    logic          ddok;
    logic [DW-1:0] ddata;
    logic          cv;
    logic          cw;
    logic [AW-1:0] ca;
    logic [2:0]    cs;
    logic [SW-1:0] cst;
    logic [DW-1:0] cd;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus: index 0 = round-robin, index 1 = fixed dbus priority.
  logic          rst  [2];
  logic          iv   [2];
  logic [AW-1:0] ia   [2];
  logic          dv   [2];
  logic [AW-1:0] da   [2];
  logic [2:0]    ds   [2];
  logic [SW-1:0] dst  [2];
  logic [DW-1:0] dd   [2];
  logic          cok  [2];
  logic [DW-1:0] cdat [2];
  obs_t          obs  [2];

  for (genvar g = 0; g < 2; g++) begin : lane
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(
      .FIXED_DPRIO (g == 1),
      .ADDR_W      (AW),
      .DATA_W      (DW)
    ) dut (
      .clk   (clk),
      .reset (rst[g]),
      .bus   (bus)
    );

    assign bus.ireq_valid  = iv[g];
    assign bus.ireq_addr   = ia[g];
    assign bus.dreq_valid  = dv[g];
    assign bus.dreq_addr   = da[g];
    assign bus.dreq_size   = ds[g];
    assign bus.dreq_strobe = dst[g];
    assign bus.dreq_data   = dd[g];
    assign bus.cresp_ok    = cok[g];
    assign bus.cresp_data  = cdat[g];

    assign obs[g] = '{iaok: bus.iresp_addr_ok, idok: bus.iresp_data_ok, idata: bus.iresp_data,
                      daok: bus.dresp_addr_ok, ddok: bus.dresp_data_ok, ddata: bus.dresp_data,
                      cv: bus.creq_valid, cw: bus.creq_is_write, ca: bus.creq_addr,
                      cs: bus.creq_size, cst: bus.creq_strobe, cd: bus.creq_data};
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input int d, input logic [63:0] got,
                       input logic [63:0] exp);
    total = total + 1;
    assert (got === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s dut%0d: got %h, expected %h", tag, d, got, exp);
    end
  endtask

  // Reference model: who currently owns the memory port (-1 none, 0 ibus, 1 dbus),
  // who was served last, and the request that the owner put on the port.
  int            owner    [2];
  int            last     [2];
  logic [AW-1:0] m_addr   [2];
  logic [2:0]    m_size   [2];
  logic [SW-1:0] m_strb   [2];
  logic [DW-1:0] m_data   [2];
  logic          rst_prev [2];
  int            served   [2][2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; iv[d] = 1'b0; ia[d] = '0; dv[d] = 1'b0; da[d] = '0;
      ds[d] = '0; dst[d] = '0; dd[d] = '0; cok[d] = 1'b0; cdat[d] = '0;
      owner[d] = -1; last[d] = 1; rst_prev[d] = 1'b1;
      m_addr[d] = '0; m_size[d] = '0; m_strb[d] = '0; m_data[d] = '0;
      served[d][0] = 0; served[d][1] = 0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rst[d] = (cyc < 2) || ($urandom_range(0, 59) == 0);
        if (!iv[d] && ($urandom_range(0, 1) == 1)) begin
          iv[d] = 1'b1;
          ia[d] = {$urandom, $urandom};
        end
        if (!dv[d] && ($urandom_range(0, 1) == 1)) begin
          dv[d]  = 1'b1;
          da[d]  = {$urandom, $urandom};
          ds[d]  = 3'($urandom_range(0, 3));
          dst[d] = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
          dd[d]  = {$urandom, $urandom};
        end
        // Random memory latency; also lands in IDLE cycles as spurious completions.
        cok[d]  = !rst[d] && ($urandom_range(0, 2) == 0);
        cdat[d] = {$urandom, $urandom};
      end

      #1;
      for (int d = 0; d < 2; d++) begin
        logic          busy;
        logic          ei;
        logic          ed;
        logic [31:0]   eidata;
        logic [63:0]   word;
        int            win;

        busy   = (owner[d] != -1);
        ei     = busy && cok[d] && (owner[d] == 0);
        ed     = busy && cok[d] && (owner[d] == 1);
        word   = cdat[d];
        eidata = !ei ? 32'h0 : (m_addr[d][2] ? word[63:32] : word[31:0]);

        check("creq_valid", d, 64'(obs[d].cv), 64'(busy));
        if (busy) begin
          check("creq_addr",     d, obs[d].ca,        m_addr[d]);
          check("creq_size",     d, 64'(obs[d].cs),   64'(m_size[d]));
          check("creq_strobe",   d, 64'(obs[d].cst),  64'(m_strb[d]));
          check("creq_data",     d, obs[d].cd,        m_data[d]);
          check("creq_is_write", d, 64'(obs[d].cw),   64'(m_strb[d] != '0));
        end
        if (rst_prev[d]) begin
          check("rst_creq_addr",  d, obs[d].ca,        64'h0);
          check("rst_creq_size",  d, 64'(obs[d].cs),   64'h0);
          check("rst_creq_strb",  d, 64'(obs[d].cst),  64'h0);
          check("rst_creq_data",  d, obs[d].cd,        64'h0);
          check("rst_creq_wr",    d, 64'(obs[d].cw),   64'h0);
        end
        check("iresp_addr_ok", d, 64'(obs[d].iaok),  64'(ei));
        check("iresp_data_ok", d, 64'(obs[d].idok),  64'(ei));
        check("iresp_data",    d, 64'(obs[d].idata), 64'(eidata));
        check("dresp_addr_ok", d, 64'(obs[d].daok),  64'(ed));
        check("dresp_data_ok", d, 64'(obs[d].ddok),  64'(ed));
        check("dresp_data",    d, obs[d].ddata,      ed ? word : 64'h0);

        // Advance the model across the coming clock edge.
        rst_prev[d] = rst[d];
        if (rst[d]) begin
          owner[d] = -1;
          last[d]  = 1;
        end else if (busy) begin
          if (cok[d]) begin
            served[d][owner[d]] = served[d][owner[d]] + 1;
            if (owner[d] == 0) iv[d] = 1'b0;
            else               dv[d] = 1'b0;
            last[d]  = owner[d];
            owner[d] = -1;
          end
        end else begin
          if (iv[d] && dv[d])  win = (d == 1) ? 1 : ((last[d] == 1) ? 0 : 1);
          else if (dv[d])      win = 1;
          else if (iv[d])      win = 0;
          else                 win = -1;
          if (win == 0) begin
            m_addr[d] = ia[d]; m_size[d] = 3'd2; m_strb[d] = '0; m_data[d] = '0;
          end else if (win == 1) begin
            m_addr[d] = da[d]; m_size[d] = ds[d]; m_strb[d] = dst[d]; m_data[d] = dd[d];
          end
          owner[d] = win;
        end
      end
    end

    for (int d = 0; d < 2; d++) begin
      check("ibus_served", d, 64'(served[d][0] > 0), 64'h1);
      check("dbus_served", d, 64'(served[d][1] > 0), 64'h1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
